gradient_scheduler: RTL

Sequences the `gradient_image` engine across every image of the scale-space pyramid. For each image it selects the octave and scale, configures the image dimensions and pulses the engine's start. It then waits for the engine's done, or flags a timeout. Before moving on, it hands the finished gradient buffers to the downstream consumer with a valid/ack handshake. It sits between the pyramid builder (upstream, `start_in`) and the orientation/descriptor stage (downstream, `result_*`), and it drives the BRAM bank-select muxes.

---
 rtl/gradient_scheduler_if.sv | 22 ++
 rtl/gradient_scheduler.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/gradient_scheduler_if.sv
// Handshake bundle between the scheduler, the gradient engine and the downstream consumer.
// master = scheduler side, slave = engine/consumer side.
interface gradient_scheduler_if;
    logic grad_start_out;
    logic grad_done_in;
    logic result_valid_out;
    logic result_ack_in;

    modport master (
        output grad_start_out,
        output result_valid_out,
        input  grad_done_in,
        input  result_ack_in
    );

    modport slave (
        input  grad_start_out,
        input  result_valid_out,
        output grad_done_in,
        output result_ack_in
    );
endinterface

// File: rtl/gradient_scheduler.sv
// Walks the gradient engine over every (octave, scale) image of the pyramid, with timeout,
// abort and a valid/ack handoff of the finished buffers to the downstream stage.
module gradient_scheduler #(
    parameter int unsigned NUM_OCTAVES = 3,
    parameter int unsigned NUM_SCALES  = 4,
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned HEIGHT      = 64,
    parameter int unsigned TIMEOUT     = 65535,
    localparam int unsigned OCT_W  = (NUM_OCTAVES > 1) ? $clog2(NUM_OCTAVES) : 1,
    localparam int unsigned SCL_W  = (NUM_SCALES > 1) ? $clog2(NUM_SCALES) : 1,
    localparam int unsigned CW_W   = $clog2(WIDTH + 1),
    localparam int unsigned CH_W   = $clog2(HEIGHT + 1)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic                 abort_in,
    output logic                 busy_out,
    output logic                 all_done_out,
    output logic                 error_out,
    output logic [OCT_W-1:0]     octave_out,
    output logic [SCL_W-1:0]     scale_out,
    output logic [CW_W-1:0]      cur_width_out,
    output logic [CH_W-1:0]      cur_height_out,
    gradient_scheduler_if.master hs
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CW_W-1:0]  WIDTH_V    = CW_W'(WIDTH);
    localparam logic [CH_W-1:0]  HEIGHT_V   = CH_W'(HEIGHT);
    localparam logic [OCT_W-1:0] OCT_LAST   = OCT_W'(NUM_OCTAVES - 1);
    localparam logic [SCL_W-1:0] SCL_LAST   = SCL_W'(NUM_SCALES - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StSelect  = 3'd1;
    localparam logic [2:0] StStart   = 3'd2;
    localparam logic [2:0] StRun     = 3'd3;
    localparam logic [2:0] StHandoff = 3'd4;
    localparam logic [2:0] StDrain   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [OCT_W-1:0] oct_q, oct_d;
    logic [SCL_W-1:0] scl_q, scl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic [CW_W-1:0]  width_q;
    logic [CH_W-1:0]  height_q;

    logic [CNT_W-1:0] cnt_inc;
    logic             expire;
    logic             last_img;

    // cnt_q holds the number of RUN/DRAIN cycles already completed for this image.
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign expire   = (cnt_inc == CNT_LIMIT);
    assign last_img = (oct_q == OCT_LAST) && (scl_q == SCL_LAST);

    always_comb begin
        state_d = state_q;
        oct_d   = oct_q;
        scl_d   = scl_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                oct_d = '0;
                scl_d = '0;
                if (start_in) begin
                    err_d   = 1'b0;
                    state_d = StSelect;
                end
            end
            StSelect: begin
                state_d = abort_in ? StIdle : StStart;
            end
            StStart: begin
                // The start pulse is already out, so an abort here must still drain the engine.
                cnt_d   = '0;
                state_d = abort_in ? StDrain : StRun;
            end
            StRun: begin
                cnt_d = cnt_inc;
                if (hs.grad_done_in) begin
                    state_d = StHandoff;
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (abort_in) begin
                    state_d = StDrain;
                end
            end
            StHandoff: begin
                if (abort_in) begin
                    state_d = StIdle;
                end else if (hs.result_ack_in) begin
                    if (last_img) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        if (scl_q == SCL_LAST) begin
                            scl_d = '0;
                            oct_d = oct_q + OCT_W'(1);
                        end else begin
                            scl_d = scl_q + SCL_W'(1);
                        end
                        state_d = StSelect;
                    end
                end
            end
            StDrain: begin
                cnt_d = cnt_inc;
                if (hs.grad_done_in) begin
                    state_d = StIdle;
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= StIdle;
            oct_q    <= '0;
            scl_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            width_q  <= '0;
            height_q <= '0;
        end else begin
            state_q  <= state_d;
            oct_q    <= oct_d;
            scl_q    <= scl_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            done_q   <= done_d;
            // Registered alongside the octave so the bank mux sees a glitch-free size.
            width_q  <= WIDTH_V >> oct_d;
            height_q <= HEIGHT_V >> oct_d;
        end
    end

    assign busy_out            = (state_q != StIdle);
    assign all_done_out        = done_q;
    assign error_out           = err_q;
    assign octave_out          = oct_q;
    assign scale_out           = scl_q;
    assign cur_width_out       = width_q;
    assign cur_height_out      = height_q;
    assign hs.grad_start_out   = (state_q == StStart);
    assign hs.result_valid_out = (state_q == StHandoff);

endmodule
